// File: rtl/store_queue_mw_if.sv
// Store queue bus interface.
// Groups every non-clock signal of store_queue_mw:
//   master (LSU/ROB side) : alloc lanes, AGU result, CDB snoop, commit,
//                           flush, fire/success notifications
//   slave  (store queue)  : alloc_ready, per-entry status/fields, pointers
interface store_queue_mw_if #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 5,
  parameter int STQ_SIZE      = 8,
  parameter int STQ_TAG_WIDTH = $clog2(STQ_SIZE) + 1,
  parameter int ALLOC_WIDTH   = 2,
  parameter int CDB_PORTS     = 2
);
  localparam int IW = $clog2(STQ_SIZE);

  logic [ALLOC_WIDTH-1:0]                    alloc_valid;
  logic [ALLOC_WIDTH-1:0][ROB_TAG_WIDTH-1:0] alloc_rob_tag;
  logic [ALLOC_WIDTH-1:0][1:0]               alloc_size;
  logic [ALLOC_WIDTH-1:0][XLEN-1:0]          alloc_data;
  logic [ALLOC_WIDTH-1:0]                    alloc_data_valid;
  logic                                      alloc_ready;

  logic                     agu_valid;
  logic [XLEN-1:0]          agu_address;
  logic [ROB_TAG_WIDTH-1:0] agu_rob_tag;

  logic [CDB_PORTS-1:0]                    cdb_active;
  logic [CDB_PORTS-1:0][XLEN-1:0]          cdb_data;
  logic [CDB_PORTS-1:0][ROB_TAG_WIDTH-1:0] cdb_tag;

  logic                     rob_commit;
  logic [ROB_TAG_WIDTH-1:0] rob_commit_tag;
  logic                     flush;
  logic [ROB_TAG_WIDTH-1:0] flush_rob_tag;
  logic                     store_fired;
  logic [IW-1:0]            store_fired_index;
  logic                     store_succeeded;
  logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag;

  logic [STQ_SIZE-1:0] stq_valid, stq_address_valid, stq_data_valid;
  logic [STQ_SIZE-1:0] stq_committed, stq_executed, stq_succeeded, stq_misaligned;
  logic [STQ_SIZE-1:0][XLEN-1:0]          stq_address, stq_data;
  logic [STQ_SIZE-1:0][3:0]               stq_byte_mask;
  logic [STQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] stq_rob_tag;
  logic [STQ_TAG_WIDTH-1:0] head, tail, count;
  logic full, empty;

  modport master (
    output alloc_valid, alloc_rob_tag, alloc_size, alloc_data, alloc_data_valid,
    output agu_valid, agu_address, agu_rob_tag,
    output cdb_active, cdb_data, cdb_tag,
    output rob_commit, rob_commit_tag, flush, flush_rob_tag,
    output store_fired, store_fired_index, store_succeeded, store_succeeded_rob_tag,
    input  alloc_ready,
    input  stq_valid, stq_address_valid, stq_data_valid, stq_committed,
    input  stq_executed, stq_succeeded, stq_misaligned,
    input  stq_address, stq_data, stq_byte_mask, stq_rob_tag,
    input  head, tail, count, full, empty
  );

  modport slave (
    input  alloc_valid, alloc_rob_tag, alloc_size, alloc_data, alloc_data_valid,
    input  agu_valid, agu_address, agu_rob_tag,
    input  cdb_active, cdb_data, cdb_tag,
    input  rob_commit, rob_commit_tag, flush, flush_rob_tag,
    input  store_fired, store_fired_index, store_succeeded, store_succeeded_rob_tag,
    output alloc_ready,
    output stq_valid, stq_address_valid, stq_data_valid, stq_committed,
    output stq_executed, stq_succeeded, stq_misaligned,
    output stq_address, stq_data, stq_byte_mask, stq_rob_tag,
    output head, tail, count, full, empty
  );
endinterface

// File: rtl/store_queue_mw.sv
// Multi-wide store queue: in-order allocation of up to ALLOC_WIDTH stores per
// cycle, AGU/CDB capture, commit/fire/success tracking, in-order retire of up
// to RETIRE_WIDTH succeeded head entries, self-recomputing tail on flush.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset
//   bus   - store_queue_mw_if slave modport (all request/status signals)
module store_queue_mw #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 5,
  parameter int STQ_SIZE      = 8,
  parameter int STQ_TAG_WIDTH = $clog2(STQ_SIZE) + 1,
  parameter int ALLOC_WIDTH   = 2,
  parameter int CDB_PORTS     = 2,
  parameter int RETIRE_WIDTH  = 2
) (
  input logic           clk,
  input logic           reset,
  store_queue_mw_if.slave bus
);
  localparam int IW = $clog2(STQ_SIZE);
  localparam int TW = STQ_TAG_WIDTH;
  localparam logic [TW-1:0] SIZE_T = TW'(STQ_SIZE);

  logic [TW-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic [TW-1:0] w_count, w_ret_n, w_alloc_n, w_surv;
  logic [STQ_SIZE-1:0] r_valid, r_addr_v, r_data_v, r_commit, r_exec, r_succ, r_misal;
  logic [STQ_SIZE-1:0] w_valid, w_addr_v, w_data_v, w_commit, w_exec, w_succ, w_misal;
  logic [STQ_SIZE-1:0][XLEN-1:0]          r_addr, r_data, w_addr, w_data;
  logic [STQ_SIZE-1:0][3:0]               r_mask, w_mask;
  logic [STQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] r_tag, w_tag;
  logic [STQ_SIZE-1:0][1:0]               r_size, w_size;
  logic [STQ_SIZE-1:0] w_clr, w_kill;
  logic w_alloc_ready, w_alloc_ok;

  assign w_count       = r_tail - r_head;
  assign w_alloc_ready = (SIZE_T - w_count) >= TW'(ALLOC_WIDTH);
  assign w_alloc_ok    = w_alloc_ready & ~bus.flush;

  // Kill / retire masks, all from registered state.
  always_comb begin
    logic [ROB_TAG_WIDTH-1:0] diff;
    logic [IW-1:0]            hidx;
    logic                     stop;
    diff    = '0;
    hidx    = '0;
    stop    = 1'b0;
    w_kill  = '0;
    w_clr   = '0;
    w_ret_n = '0;
    w_surv  = '0;
    for (int e = 0; e < STQ_SIZE; e++) begin
      // Tag distance sign decides age: non-negative means same or younger.
      diff      = r_tag[e] - bus.flush_rob_tag;
      w_kill[e] = bus.flush & r_valid[e] & ~diff[ROB_TAG_WIDTH-1];
      if (r_valid[e] && !w_kill[e]) w_surv = w_surv + TW'(1);
    end
    // Retire stops at the first entry that is not both valid and succeeded.
    for (int r = 0; r < RETIRE_WIDTH; r++) begin
      hidx = r_head[IW-1:0] + IW'(r);
      if (!stop && r_valid[hidx] && r_succ[hidx]) begin
        w_clr[hidx] = 1'b1;
        w_ret_n     = w_ret_n + TW'(1);
      end else begin
        stop = 1'b1;
      end
    end
    w_clr = w_clr | w_kill;
  end

  // Next entry state: field updates, then allocate overrides, then clear wins.
  always_comb begin
    logic [3:0]      base;
    logic [XLEN-1:0] a;
    logic            hit;
    logic [IW-1:0]   aidx;
    base = '0; a = '0; hit = 1'b0; aidx = '0; w_alloc_n = '0;
    w_valid = r_valid; w_addr_v = r_addr_v; w_data_v = r_data_v; w_commit = r_commit;
    w_exec  = r_exec;  w_succ   = r_succ;   w_misal  = r_misal;
    w_addr  = r_addr;  w_data   = r_data;   w_mask   = r_mask;
    w_tag   = r_tag;   w_size   = r_size;

    for (int e = 0; e < STQ_SIZE; e++) begin
      if (r_valid[e]) begin
        if (bus.agu_valid && r_tag[e] == bus.agu_rob_tag) begin
          a = bus.agu_address;
          case (r_size[e])
            2'd0:    base = 4'h1;
            2'd1:    base = 4'h3;
            default: base = 4'hF;
          endcase
          w_addr[e]   = a;
          w_addr_v[e] = 1'b1;
          w_mask[e]   = base << a[1:0];
          w_misal[e]  = (r_size[e] == 2'd1 && a[0]) ||
                        (r_size[e] == 2'd2 && a[1:0] != 2'b00);
        end
        hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (!hit && bus.cdb_active[p] && bus.cdb_tag[p] == r_tag[e]) begin
            w_data[e]   = bus.cdb_data[p];
            w_data_v[e] = 1'b1;
            hit         = 1'b1;
          end
        end
        if (bus.rob_commit && r_tag[e] == bus.rob_commit_tag)               w_commit[e] = 1'b1;
        if (bus.store_fired && bus.store_fired_index == IW'(e))             w_exec[e]   = 1'b1;
        if (bus.store_succeeded && r_tag[e] == bus.store_succeeded_rob_tag) w_succ[e]   = 1'b1;
      end
    end

    // Valid lanes are packed contiguously starting at tail.
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      if (w_alloc_ok && bus.alloc_valid[k]) begin
        aidx           = r_tail[IW-1:0] + w_alloc_n[IW-1:0];
        w_valid[aidx]  = 1'b1;
        w_tag[aidx]    = bus.alloc_rob_tag[k];
        w_size[aidx]   = bus.alloc_size[k];
        w_data[aidx]   = bus.alloc_data[k];
        w_data_v[aidx] = bus.alloc_data_valid[k];
        w_addr[aidx]   = '0;
        w_addr_v[aidx] = 1'b0;
        w_mask[aidx]   = '0;
        w_misal[aidx]  = 1'b0;
        w_commit[aidx] = 1'b0;
        w_exec[aidx]   = 1'b0;
        w_succ[aidx]   = 1'b0;
        hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (!hit && bus.cdb_active[p] && bus.cdb_tag[p] == bus.alloc_rob_tag[k]) begin
            w_data[aidx]   = bus.cdb_data[p];
            w_data_v[aidx] = 1'b1;
            hit            = 1'b1;
          end
        end
        w_alloc_n = w_alloc_n + TW'(1);
      end
    end

    for (int e = 0; e < STQ_SIZE; e++) begin
      if (w_clr[e]) begin
        w_valid[e] = 1'b0; w_addr_v[e] = 1'b0; w_data_v[e] = 1'b0; w_commit[e] = 1'b0;
        w_exec[e]  = 1'b0; w_succ[e]   = 1'b0; w_misal[e]  = 1'b0;
        w_addr[e]  = '0;   w_data[e]   = '0;   w_mask[e]   = '0;
        w_tag[e]   = '0;   w_size[e]   = '0;
      end
    end

    w_head_nxt = r_head + w_ret_n;
    // Survivors include entries retiring this cycle: they sit in front of the
    // remaining ones, so the tail lands right after the youngest survivor.
    w_tail_nxt = bus.flush ? (r_head + w_surv) : (r_tail + w_alloc_n);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= '0; r_tail <= '0;
      r_valid <= '0; r_addr_v <= '0; r_data_v <= '0; r_commit <= '0;
      r_exec  <= '0; r_succ   <= '0; r_misal  <= '0;
      r_addr  <= '0; r_data   <= '0; r_mask   <= '0; r_tag <= '0; r_size <= '0;
    end else begin
      r_head <= w_head_nxt; r_tail <= w_tail_nxt;
      r_valid <= w_valid; r_addr_v <= w_addr_v; r_data_v <= w_data_v; r_commit <= w_commit;
      r_exec  <= w_exec;  r_succ   <= w_succ;   r_misal  <= w_misal;
      r_addr  <= w_addr;  r_data   <= w_data;   r_mask   <= w_mask; r_tag <= w_tag; r_size <= w_size;
    end
  end

  assign bus.alloc_ready       = w_alloc_ready;
  assign bus.head              = r_head;
  assign bus.tail              = r_tail;
  assign bus.count             = w_count;
  assign bus.full              = (w_count == SIZE_T);
  assign bus.empty             = (w_count == '0);
  assign bus.stq_valid         = r_valid;
  assign bus.stq_address_valid = r_addr_v;
  assign bus.stq_data_valid    = r_data_v;
  assign bus.stq_committed     = r_commit;
  assign bus.stq_executed      = r_exec;
  assign bus.stq_succeeded     = r_succ;
  assign bus.stq_misaligned    = r_misal;
  assign bus.stq_address       = r_addr;
  assign bus.stq_data          = r_data;
  assign bus.stq_byte_mask     = r_mask;
  assign bus.stq_rob_tag       = r_tag;
endmodule
